// File: rtl/apb_mem_slave_if.sv
// APB3/APB4 bus bundle between one master and the apb_mem_slave memory.
// Latency: none, this file only carries wires.
// Backpressure: the slave stalls the master by holding PREADY low.
// Optional feature macro: APB_SLV_PSTRB_EN adds the PSTRB byte-lane enables.
interface apb_mem_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Request side, driven by the master
    logic                    PSELx;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
`ifdef APB_SLV_PSTRB_EN
    logic [DATA_WIDTH/8-1:0] PSTRB;
`endif

    // Response side, driven by the slave
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

`ifdef APB_SLV_PSTRB_EN
    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
`else
    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
`endif
endinterface

// File: rtl/apb_mem_slave.sv
// APB slave backed by a flop memory, with error response on bad addresses and protocol-abort reporting.
// Latency: setup + access = 2 cycles, plus WAIT_STATES cycles with PREADY low in every access phase.
// Backpressure: PREADY low stalls the master; an abandoned access returns to IDLE and pulses proto_err.
// Optional feature macro: APB_SLV_PSTRB_EN enables per-byte write strobes (PSTRB).
module apb_mem_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_mem_slave_if.slave    apb,
    output logic              proto_err
);

    localparam int NBYTES = DATA_WIDTH / 8;
    // Byte offset bits inside one word; zero for 8-bit data
    localparam int LSB    = $clog2(NBYTES);
    localparam int MIDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // One extra bit so MEM_DEPTH is always representable in the range compare
    localparam int IDX_W  = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);
    localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_STATES);

    // Reject configurations the datapath cannot represent
    generate
        if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
            $error("apb_mem_slave: DATA_WIDTH must be 8, 16, 32 or 64");
        end
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
            $error("apb_mem_slave: WAIT_STATES must be in 0..15");
        end
        if (MEM_DEPTH < 1) begin : g_bad_depth
            $error("apb_mem_slave: MEM_DEPTH must be at least 1");
        end
        if (MIDX_W > ADDR_WIDTH) begin : g_bad_addr_width
            $error("apb_mem_slave: ADDR_WIDTH too small to address MEM_DEPTH words");
        end
    endgenerate

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0]  word_idx;
    logic [MIDX_W-1:0]      mem_idx;
    logic                   misaligned;
    logic                   out_of_range;
    logic                   bad_addr;
    logic                   xfer_done;
    logic                   proto_viol;
    logic                   wr_en;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic [DATA_WIDTH-1:0]  wr_word;

    // Address decode straight from the live bus; the master holds PADDR stable through ACCESS
    assign word_idx     = apb.PADDR >> LSB;
    assign mem_idx      = word_idx[MIDX_W-1:0];
    assign misaligned   = |(apb.PADDR & ALIGN_MASK);
    assign out_of_range = IDX_W'(word_idx) >= IDX_W'(MEM_DEPTH);
    assign bad_addr     = misaligned | out_of_range;

    // Only dereferenced when bad_addr is clear, so mem_idx is always in range when it matters
    assign rd_word = mem_q[mem_idx];

    // Next-state, wait counter and protocol checking for the setup/access sequence
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        xfer_done  = 1'b0;
        proto_viol = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (apb.PSELx && !apb.PENABLE) begin
                    state_d    = S_ACCESS;
                    wait_cnt_d = WAIT_INIT;
                end else if (apb.PSELx && apb.PENABLE) begin
                    // Access phase without a preceding setup phase: report, ignore
                    proto_viol = 1'b1;
                end
            end
            S_ACCESS: begin
                if (!apb.PSELx || !apb.PENABLE) begin
                    // Master walked away mid-transfer; nothing is written
                    state_d    = S_IDLE;
                    wait_cnt_d = '0;
                    proto_viol = 1'b1;
                end else if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else begin
                    xfer_done = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // FSM state and wait counter registers
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Response is combinational so PREADY/PSLVERR/PRDATA appear in the completing cycle itself
    assign apb.PREADY  = xfer_done;
    assign apb.PSLVERR = xfer_done & bad_addr;
    assign apb.PRDATA  = (xfer_done && !apb.PWRITE && !bad_addr) ? rd_word : '0;
    // No violation is reported while the block is held in reset
    assign proto_err   = proto_viol & ~PRESET;

    assign wr_en = xfer_done & apb.PWRITE & ~bad_addr;

`ifdef APB_SLV_PSTRB_EN
    // Merge enabled byte lanes over the current word; all-zero strobes rewrite the old value
    always_comb begin
        wr_word = rd_word;
        for (int b = 0; b < NBYTES; b++) begin
            if (apb.PSTRB[b]) begin
                wr_word[b*8 +: 8] = apb.PWDATA[b*8 +: 8];
            end
        end
    end
`else
    // Without strobes every write replaces the whole word
    always_comb begin
        wr_word = apb.PWDATA;
    end
`endif

    // Memory array: cleared by reset, written on the completing edge of a good write
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[mem_idx] <= wr_word;
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances with WAIT_STATES 0, 3 and 2 share one driven bus,
// qualified per instance by PSELx; expected responses come from a small memory model via a queue.
// Strobe scenario is only built when APB_SLV_PSTRB_EN is defined.
module tb_apb_mem_slave;

    logic        PCLK = 1'b0;
    logic        PRESET;

    always #5 PCLK = ~PCLK;

    // Shared master-side drive; sel picks which instance sees PSELx
    int          sel;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
`ifdef APB_SLV_PSTRB_EN
    logic [3:0]  pstrb;
`endif

    logic        perr0, perr1, perr2;
    logic        pready, pslverr, proto;
    logic [31:0] prdata;

    apb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    apb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
    apb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

    assign bus0.PSELx = psel && (sel == 0);
    assign bus1.PSELx = psel && (sel == 1);
    assign bus2.PSELx = psel && (sel == 2);
    assign bus0.PENABLE = penable;
    assign bus1.PENABLE = penable;
    assign bus2.PENABLE = penable;
    assign bus0.PWRITE = pwrite;
    assign bus1.PWRITE = pwrite;
    assign bus2.PWRITE = pwrite;
    assign bus0.PADDR = paddr;
    assign bus1.PADDR = paddr;
    assign bus2.PADDR = paddr;
    assign bus0.PWDATA = pwdata;
    assign bus1.PWDATA = pwdata;
    assign bus2.PWDATA = pwdata;
`ifdef APB_SLV_PSTRB_EN
    assign bus0.PSTRB = pstrb;
    assign bus1.PSTRB = pstrb;
    assign bus2.PSTRB = pstrb;
`endif

    apb_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .apb(bus0), .proto_err(perr0));
    apb_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .apb(bus1), .proto_err(perr1));
    apb_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut2 (
        .PCLK(PCLK), .PRESET(PRESET), .apb(bus2), .proto_err(perr2));

    always_comb begin
        pready  = bus0.PREADY;
        pslverr = bus0.PSLVERR;
        prdata  = bus0.PRDATA;
        proto   = perr0;
        case (sel)
            1: begin pready = bus1.PREADY; pslverr = bus1.PSLVERR; prdata = bus1.PRDATA; proto = perr1; end
            2: begin pready = bus2.PREADY; pslverr = bus2.PSLVERR; prdata = bus2.PRDATA; proto = perr2; end
            default: ;
        endcase
    end

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model [3][256];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic int ws_of(input int d);
        return (d == 1) ? 3 : (d == 2) ? 2 : 0;
    endfunction

    function automatic bit model_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd256);
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 256; i++)
                model[d][i] = 32'h0;
    endtask

    task automatic bus_idle(input int n);
        psel = 1'b0;
        penable = 1'b0;
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // One full transfer; starts and ends 1 time unit after a rising edge, leaving the bus selected
    task automatic apb_xfer(input string name, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        exp_t e;
        int   waits;
        bit   done;
        bit   perr_seen;
        e.name  = name;
        e.err   = model_bad(addr);
        e.waits = ws_of(sel);
        e.rdata = (!wr && !e.err) ? model[sel][addr[9:2]] : 32'h0;
        if (wr && !e.err) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[sel][addr[9:2]][b*8 +: 8] = data[b*8 +: 8];
        end
        sbq.push_back(e);

        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
`ifdef APB_SLV_PSTRB_EN
        pstrb = strb;
`endif
        @(negedge PCLK);
        n_cmp++;
        if (pready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s setup_pready: got %b expected 0", name, pready);
        end
        @(posedge PCLK); #1;
        penable = 1'b1;
        waits = 0; done = 0; perr_seen = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge PCLK);
            if (proto === 1'b1) perr_seen = 1;
            if (pready === 1'b1) done = 1;
            else waits++;
        end
        e = sbq.pop_front();
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s timeout: PREADY never rose within 40 cycles", e.name);
        end else begin
            n_cmp += 3;
            if (waits != e.waits) begin
                n_bad++;
                $display("FAIL %s wait_cycles: got %0d expected %0d", e.name, waits, e.waits);
            end
            if (pslverr !== e.err) begin
                n_bad++;
                $display("FAIL %s pslverr: got %b expected %b", e.name, pslverr, e.err);
            end
            if (prdata !== e.rdata) begin
                n_bad++;
                $display("FAIL %s prdata: got %h expected %h", e.name, prdata, e.rdata);
            end
        end
        if (perr_seen) begin
            n_bad++;
            $display("FAIL %s proto_err: got 1 expected 0 during legal transfer", e.name);
        end
        @(posedge PCLK); #1;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        n_cmp += 4;
        if (pready !== 1'b0)   begin n_bad++; $display("FAIL reset_pready: got %b expected 0", pready); end
        if (pslverr !== 1'b0)  begin n_bad++; $display("FAIL reset_pslverr: got %b expected 0", pslverr); end
        if (prdata !== 32'h0)  begin n_bad++; $display("FAIL reset_prdata: got %h expected 0", prdata); end
        if (proto !== 1'b0)    begin n_bad++; $display("FAIL reset_proto_err: got %b expected 0", proto); end
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        model_clear();
        bus_idle(1);
        // Freshly reset memory reads as zero
        apb_xfer("rd_after_reset", 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        bus_idle(1);
    endtask

    task automatic test_defaults();
        sel = 0;
        apb_xfer("wr_0x10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        apb_xfer("rd_0x10", 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        bus_idle(1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        addrs[0] = 32'h14; addrs[1] = 32'h18; addrs[2] = 32'h0; addrs[3] = 32'h3F8;
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            apb_xfer("b2b_wr", 1'b1, addrs[i], 32'h1000_0000 + 32'(i * 32'h0101_0101), 4'hF);
            apb_xfer("b2b_rd", 1'b0, addrs[i], 32'h0, 4'hF);
        end
        // Overwrite then read again: the earlier value must be gone
        apb_xfer("b2b_rewr", 1'b1, 32'h14, 32'h5A5A_0F0F, 4'hF);
        apb_xfer("b2b_reread", 1'b0, 32'h14, 32'h0, 4'hF);
        apb_xfer("b2b_rd_0x10", 1'b0, 32'h10, 32'h0, 4'hF);
        bus_idle(1);
    endtask

    task automatic test_wait_states();
        sel = 1;
        apb_xfer("ws3_wr_0x40", 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF);
        apb_xfer("ws3_rd_0x40", 1'b0, 32'h0000_0040, 32'h0, 4'hF);
        apb_xfer("ws3_rd_bad", 1'b0, 32'h0000_0400, 32'h0, 4'hF);
        bus_idle(1);
        sel = 0;
    endtask

    task automatic test_bad_addr();
        sel = 0;
        apb_xfer("rd_0x400_oor", 1'b0, 32'h0000_0400, 32'h0, 4'hF);
        apb_xfer("wr_0x402_mis", 1'b1, 32'h0000_0402, 32'h1111_2222, 4'hF);
        apb_xfer("rd_0x400_again", 1'b0, 32'h0000_0400, 32'h0, 4'hF);
        apb_xfer("wr_0x12_mis", 1'b1, 32'h0000_0012, 32'h3333_4444, 4'hF);
        apb_xfer("rd_0x10_kept", 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        apb_xfer("rd_0x11_mis", 1'b0, 32'h0000_0011, 32'h0, 4'hF);
        apb_xfer("wr_last_word", 1'b1, 32'h0000_03FC, 32'hA5A5_5A5A, 4'hF);
        apb_xfer("rd_last_word", 1'b0, 32'h0000_03FC, 32'h0, 4'hF);
        apb_xfer("rd_far_high", 1'b0, 32'h8000_0000, 32'h0, 4'hF);
        bus_idle(1);
    endtask

    task automatic test_proto_abort();
        sel = 2;
        apb_xfer("ws2_wr_0x30", 1'b1, 32'h0000_0030, 32'h0000_0055, 4'hF);
        bus_idle(1);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'h0000_0099;
        @(negedge PCLK);
        n_cmp++;
        if (proto !== 1'b0) begin n_bad++; $display("FAIL abort_setup_proto: got %b expected 0", proto); end
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK);
        n_cmp += 2;
        if (pready !== 1'b0) begin n_bad++; $display("FAIL abort_wait_pready: got %b expected 0", pready); end
        if (proto !== 1'b0)  begin n_bad++; $display("FAIL abort_wait_proto: got %b expected 0", proto); end
        @(posedge PCLK); #1;
        penable = 1'b0;
        @(negedge PCLK);
        n_cmp += 2;
        if (proto !== 1'b1)  begin n_bad++; $display("FAIL abort_pulse: got %b expected 1", proto); end
        if (pready !== 1'b0) begin n_bad++; $display("FAIL abort_pready: got %b expected 0", pready); end
        @(posedge PCLK); #1;
        psel = 1'b0;
        @(negedge PCLK);
        n_cmp++;
        if (proto !== 1'b0) begin n_bad++; $display("FAIL abort_pulse_width: got %b expected 0", proto); end
        @(posedge PCLK); #1;
        apb_xfer("ws2_rd_after_abort", 1'b0, 32'h0000_0030, 32'h0, 4'hF);
        bus_idle(1);
        sel = 0;
    endtask

    task automatic test_enable_no_setup();
        sel = 0;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h0BAD_0BAD;
        @(negedge PCLK);
        n_cmp += 3;
        if (proto !== 1'b1)    begin n_bad++; $display("FAIL noset_proto: got %b expected 1", proto); end
        if (pready !== 1'b0)   begin n_bad++; $display("FAIL noset_pready: got %b expected 0", pready); end
        if (pslverr !== 1'b0)  begin n_bad++; $display("FAIL noset_pslverr: got %b expected 0", pslverr); end
        @(posedge PCLK); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge PCLK);
        n_cmp++;
        if (proto !== 1'b0) begin n_bad++; $display("FAIL noset_pulse_width: got %b expected 0", proto); end
        @(posedge PCLK); #1;
        apb_xfer("rd_0x10_after_noset", 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        bus_idle(1);
    endtask

    task automatic test_reset_mid();
        sel = 0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h1234_5678;
        @(posedge PCLK); #1;
        penable = 1'b1;
        #2;
        n_cmp++;
        if (pready !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_pready: got %b expected 1", pready); end
        PRESET = 1'b1;
        #1;
        n_cmp += 3;
        if (pready !== 1'b0)  begin n_bad++; $display("FAIL rstmid_pready: got %b expected 0", pready); end
        if (pslverr !== 1'b0) begin n_bad++; $display("FAIL rstmid_pslverr: got %b expected 0", pslverr); end
        if (prdata !== 32'h0) begin n_bad++; $display("FAIL rstmid_prdata: got %h expected 0", prdata); end
        @(posedge PCLK); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        model_clear();
        bus_idle(1);
        apb_xfer("rstmid_rd_0x8", 1'b0, 32'h0000_0008, 32'h0, 4'hF);
        apb_xfer("rstmid_rd_0x10", 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        bus_idle(1);
    endtask

`ifdef APB_SLV_PSTRB_EN
    task automatic test_strobe();
        sel = 0;
        apb_xfer("strb_wr_full", 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF);
        apb_xfer("strb_wr_lane0", 1'b1, 32'h0000_0020, 32'h0000_00AB, 4'b0001);
        apb_xfer("strb_rd", 1'b0, 32'h0000_0020, 32'h0, 4'h0);
        apb_xfer("strb_wr_none", 1'b1, 32'h0000_0020, 32'h1234_5678, 4'h0);
        apb_xfer("strb_wr_lane2", 1'b1, 32'h0000_0020, 32'h00CD_0000, 4'b0100);
        apb_xfer("strb_rd_again", 1'b0, 32'h0000_0020, 32'h0, 4'h0);
        bus_idle(1);
    endtask
`endif

    initial begin
        sel = 0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
`ifdef APB_SLV_PSTRB_EN
        pstrb = 4'h0;
`endif
        model_clear();
        test_reset();
        test_defaults();
        test_back_to_back();
        test_wait_states();
        test_bad_addr();
        test_proto_abort();
        test_enable_no_setup();
        test_reset_mid();
`ifdef APB_SLV_PSTRB_EN
        test_strobe();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
